// File: rtl/rs232_receiver.sv
// RS-232 8N1 receiver: oversampled, majority-voted mid-bit sampling of RxD,
// one-cycle data-ready / frame-error strobes, busy flag and line-idle detector.
module rs232_receiver #(
    parameter int ClkFrequency          = 25000000,
    parameter int Baud                  = 115200,
    parameter int Oversampling          = 16,
    parameter int BaudGeneratorAccWidth = 16,
    parameter int IdleBits              = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
    output logic       RxD_busy,
    output logic       RxD_idle
);

    localparam int W = BaudGeneratorAccWidth;

    // Increment is pre-scaled by 2^7 on both sides so the product fits for any
    // realistic clock/baud pair; rounding comes from the added half divisor.
    localparam longint INC_L =
        (((longint'(Baud) * longint'(Oversampling)) << (W - 7)) + (longint'(ClkFrequency) >> 8))
        / (longint'(ClkFrequency) >> 7);
    localparam logic [W:0] ACC_INC = (W + 1)'(INC_L);

    localparam logic [3:0] HALF_TICK = 4'(Oversampling / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(Oversampling - 1);

    localparam int IDLE_MAX = IdleBits * Oversampling;
    localparam int IW       = $clog2(IDLE_MAX + 1);
    localparam logic [IW-1:0] IDLE_SAT = IW'(IDLE_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_sync;
    logic [2:0]      r_vote;
    logic [W:0]      r_acc;
    logic [3:0]      r_tick_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [IW-1:0]   r_idle_cnt;
    logic [7:0]      r_data;
    logic            r_ready;
    logic            r_ferr;

    logic            w_rxd;
    logic            w_tick;
    logic            w_major;
    logic            w_state_chg;
    logic            w_shift_en;
    logic            w_ld_data;
    logic            w_ferr;

    assign w_rxd       = r_sync[1];
    assign w_tick      = r_acc[W];
    assign w_major     = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_vote[2]) | (r_vote[1] & r_vote[2]);
    assign w_state_chg = (w_next != r_state);

    // NOTE: sequential state is always updated with <= so every register samples
    // pre-edge values; blocking assignments here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_acc  <= '0;
        end else begin
            r_sync <= {r_sync[0], RxD};
            r_acc  <= {1'b0, r_acc[W-1:0]} + ACC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vote <= 3'b111;
        end else if (w_tick) begin
            r_vote <= {r_vote[1:0], w_rxd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that leaves one
    // unassigned would infer a latch.
    always_comb begin
        w_next     = r_state;
        w_shift_en = 1'b0;
        w_ld_data  = 1'b0;
        w_ferr     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_tick && !w_rxd) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_tick && r_tick_cnt == HALF_TICK) begin
                    w_next = w_major ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && r_tick_cnt == LAST_TICK) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_tick && r_tick_cnt == LAST_TICK) begin
                    if (w_major) begin
                        w_ld_data = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_ferr = 1'b1;
                        w_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (w_tick && w_major) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Tick counter wraps at LAST_TICK so DATA decisions recur every bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_state_chg) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= (r_tick_cnt == LAST_TICK) ? 4'd0 : r_tick_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state != S_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {w_major, r_shift[7:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_ready <= w_ld_data;
            r_ferr  <= w_ferr;
            if (w_ld_data) begin
                r_data <= r_shift;
            end
        end
    end

    // A low sample clears the count on the same edge that enters START.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (r_state != S_IDLE || (w_tick && !w_rxd)) begin
            r_idle_cnt <= '0;
        end else if (w_tick && r_idle_cnt != IDLE_SAT) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign RxD_data       = r_data;
    assign RxD_data_ready = r_ready;
    assign RxD_frame_err  = r_ferr;
    assign RxD_busy       = (r_state != S_IDLE);
    assign RxD_idle       = (r_idle_cnt == IDLE_SAT);

endmodule

// File: tb/tb_rs232_receiver.sv
// Bench for rs232_receiver: serial frames at nominal and skewed bit periods,
// checked against a frame-level model of expected bytes and error strobes.
module tb_rs232_receiver;

    localparam int NOM = 217;   // 25 MHz / 115200 baud, in clocks

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_err;
    logic       RxD_busy;
    logic       RxD_idle;

    always #20 clk = ~clk;

    rs232_receiver dut (
        .clk           (clk),
        .rst           (rst),
        .RxD           (RxD),
        .RxD_data      (RxD_data),
        .RxD_data_ready(RxD_data_ready),
        .RxD_frame_err (RxD_frame_err),
        .RxD_busy      (RxD_busy),
        .RxD_idle      (RxD_idle)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed side: collected away from the active edge.
    logic [7:0] obs_q[$];
    int obs_err       = 0;
    int both_hi       = 0;
    int cyc           = 0;
    int last_rdy_cyc  = 0;
    int prev_rdy_cyc  = 0;
    int busy_run      = 0;
    int last_busy_len = 0;

    always @(negedge clk) begin
        cyc++;
        if (RxD_data_ready === 1'b1) begin
            obs_q.push_back(RxD_data);
            prev_rdy_cyc = last_rdy_cyc;
            last_rdy_cyc = cyc;
        end
        if (RxD_frame_err === 1'b1) obs_err++;
        if (RxD_data_ready === 1'b1 && RxD_frame_err === 1'b1) both_hi++;
        if (RxD_busy === 1'b1) begin
            busy_run++;
        end else begin
            if (busy_run != 0) last_busy_len = busy_run;
            busy_run = 0;
        end
    end

    // Reference model: what a correct receiver must have reported so far.
    logic [7:0] exp_q[$];
    int         exp_err   = 0;
    logic [7:0] last_good = 8'h00;

    task automatic hold(input logic v, input int n);
        RxD = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int per, input logic stop_bit,
                              input int pre_low);
        hold(1'b0, per - pre_low);
        for (int i = 0; i < 8; i++) hold(d[i], per);
        hold(stop_bit, per);
        if (stop_bit) begin
            exp_q.push_back(d);
            last_good = d;
        end else begin
            exp_err++;
        end
    endtask

    task automatic verify(input string tag);
        check({tag, " ready count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, " byte"}, obs_q[i], exp_q[i]);
        check({tag, " RxD_data"}, RxD_data, last_good);
        check({tag, " frame_err count"}, obs_err, exp_err);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int gap;
        RxD = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("reset data", RxD_data, 8'h00);
        check("reset ready", RxD_data_ready, 1'b0);
        check("reset ferr", RxD_frame_err, 1'b0);
        check("reset busy", RxD_busy, 1'b0);
        check("reset idle", RxD_idle, 1'b0);
        rst = 1'b0;
        hold(1'b1, 2 * NOM);

        // Single frame, busy duration about 9.5 bit-times.
        send_frame(8'h55, NOM, 1'b1, 0);
        hold(1'b1, NOM);
        verify("frame 55");
        check("busy length", (last_busy_len >= 2000 && last_busy_len <= 2110), 1'b1);

        // Back-to-back frames with a single stop bit.
        send_frame(8'hA3, NOM, 1'b1, 0);
        send_frame(8'h0F, NOM, 1'b1, 0);
        hold(1'b1, NOM);
        check("b2b spacing", ((last_rdy_cyc - prev_rdy_cyc) >= 2150 &&
                              (last_rdy_cyc - prev_rdy_cyc) <= 2190), 1'b1);
        verify("b2b");

        // Glitch shorter than half a bit: false start.
        hold(1'b0, 40);
        hold(1'b1, NOM);
        check("false start busy", RxD_busy, 1'b0);
        verify("false start");

        // Bad stop bit followed by a long break: exactly one error strobe.
        send_frame(8'hFF, NOM, 1'b0, 0);
        hold(1'b0, 3000);
        hold(1'b1, 2 * NOM);
        verify("break");
        send_frame(8'h12, NOM, 1'b1, 0);
        hold(1'b1, NOM);
        verify("after break");

        // Reset during bit 4 aborts the frame silently.
        hold(1'b0, NOM);
        for (int i = 0; i < 4; i++) hold(gap[0], NOM);
        hold(1'b1, NOM / 2);
        rst = 1'b1;
        @(negedge clk);
        check("midreset data", RxD_data, 8'h00);
        check("midreset ready", RxD_data_ready, 1'b0);
        check("midreset ferr", RxD_frame_err, 1'b0);
        check("midreset busy", RxD_busy, 1'b0);
        check("midreset idle", RxD_idle, 1'b0);
        rst = 1'b0;
        last_good = 8'h00;
        hold(1'b1, 2 * NOM);
        send_frame(8'h3C, NOM, 1'b1, 0);
        hold(1'b1, NOM);
        verify("after reset");

        // +/-3% baud skew, then idle detection and its release on a start edge.
        send_frame(8'h96, 211, 1'b1, 0);
        hold(1'b1, NOM);
        verify("fast 96");
        send_frame(8'h96, 224, 1'b1, 0);
        hold(1'b1, 8 * NOM);
        check("idle early", RxD_idle, 1'b0);
        hold(1'b1, 4 * NOM);
        check("idle set", RxD_idle, 1'b1);
        hold(1'b0, 20);
        check("idle cleared", RxD_idle, 1'b0);
        check("busy on start", RxD_busy, 1'b1);
        send_frame(8'hC4, NOM, 1'b1, 20);
        hold(1'b1, NOM);
        verify("slow 96 and C4");

        // Randomized frames, skews, gaps and occasional framing errors.
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d;
            int per;
            logic good;
            d    = 8'($urandom);
            per  = int'($urandom_range(211, 224));
            good = ($urandom_range(0, 5) != 0);
            send_frame(d, per, good, 0);
            if (!good) begin
                hold(1'b0, int'($urandom_range(0, 500)));
                hold(1'b1, NOM);
            end
            gap = int'($urandom_range(0, 2)) * NOM;
            if (gap != 0) hold(1'b1, gap);
            verify("random");
        end

        hold(1'b1, NOM);
        check("ready and ferr never together", both_hi, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
